data_seq_gen: RTL and testbench
===============================

Name: data_seq_gen

Overview:
- Synthesizable, parametrised transaction sequencer for the SD host DATA block; it replaces the fixed-delay stimulus of the DATA bench.
- Issues configurable multi-operation read/write runs and emulates the physical layer (Send -> Complete after a set latency).
- Supplies FIFO handshakes and a deterministic data pattern, and runs a watchdog on the DUT.
- Sits between the DATA block under test and the bench top; it is also reusable in hardware bring-up.

Parameters:
- BLK_W, 8: width of block count and block counter.
- TO_W, 16: width of Timeout_reg.
- DATA_W, 32: width of Data_from_FIFO.
- REP_W, 4: width of operation repeat count.
- NEWDATA_CYC, 4: NewData pulse length in cycles (>=1).
- PHY_LAT, 6: cycles from Send sample to Complete pulse (>=1).
- GAP_CYC, 3: idle cycles between operations.
- WDOG_CYC, 256: watchdog limit per wait state.
- SEED, 32'hA5A50000: first data word.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin run (sampled in IDLE only)
- Cfg_write_read  in  1  1 write, 0 read
- Cfg_blocks  in  BLK_W  blocks per operation
- Cfg_multiple  in  1  multiframe flag
- Cfg_timeout_en  in  1  timeout enable to DUT
- Cfg_timeout_reg  in  TO_W  timeout cycles to DUT
- Cfg_repeat  in  REP_W  operations per run
- Send  in  1  DUT requests PHY transfer
- Idle  in  1  DUT idles PHY
- Service  in  1  DUT service request
- Data_transfer_complete  in  1  DUT operation done
- WriteRead, MultipleData, Timeout_enable  out  1  latched config
- Blocks  out  BLK_W  latched config
- Timeout_reg  out  TO_W  latched config
- NewData  out  1  operation start pulse
- Serial_ready  out  1  emulated PHY ready
- Complete  out  1  emulated PHY block done
- FIFO_ok  out  1  FIFO word valid pulse
- Timeout  out  1  emulated PHY timeout (see optional feature)
- Data_from_FIFO  out  DATA_W  pattern word
- Busy, Done, Error  out  1  status
- Ops_done  out  REP_W  completed operations
- Blocks_done  out  BLK_W  blocks completed in the current operation

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE. All outputs 0; Data_from_FIFO=0.

State machine:
- **IDLE**
  - Start=1 latches all Cfg_* into shadow registers; later Cfg changes are ignored until the next Start.
  - Ops_done, Blocks_done, Error and Done are cleared; Busy=1 from the next cycle.
  - If Cfg_blocks==0 or Cfg_repeat==0: go to DONE next cycle; no NewData is issued.
- **NEWDATA**: NewData=1 for exactly NEWDATA_CYC cycles, then WAIT_SEND.
- **WAIT_SEND**
  - Serial_ready=1 while in this state.
  - Send=1 causes, on the next cycle: FIFO_ok=1 for 1 cycle, Data_from_FIFO=current pattern, then PHY_BUSY.
  - Serial_ready drops in the same cycle.
- **PHY_BUSY**
  - Down-counter loaded with PHY_LAT-1; at 0, Complete=1 for 1 cycle and Blocks_done increments.
  - If Blocks_done (new value)==latched Blocks: go to WAIT_DONE; else return to WAIT_SEND.
- **WAIT_DONE**
  - Data_transfer_complete=1: Ops_done increments and Blocks_done clears.
  - If Ops_done==repeat: go to DONE; else GAP.
- **GAP**: GAP_CYC cycles with all handshakes low, then NEWDATA.
- **DONE**: Busy=0, Done=1, held until next Start.
- **ERROR**: Busy=0, Error=1 sticky; all handshakes low; exits only on Start or reset.

Data pattern:
- Starts at SEED for each run.
- Increments by 1 (modulo 2^DATA_W) after each FIFO_ok.
- Data_from_FIFO holds its value between pulses.

Watchdog:
- Counter clears on every state change.
- Reaching WDOG_CYC in WAIT_SEND or WAIT_DONE -> ERROR.

Protocol errors (-> ERROR next cycle):
- Data_transfer_complete=1 in any state other than WAIT_DONE, IDLE or DONE.
- Idle=1 during PHY_BUSY.

Other rules:
- Start while Busy=1 is ignored.
- Send held high across states counts once per WAIT_SEND entry.
- Service is observed only and does not change the flow.
- Simultaneous watchdog expiry and valid handshake: the handshake wins.

Optional Feature:
Macro: TIMEOUT_INJ_EN.
- **Defined**:
  - Adds input Cfg_inject_blk [BLK_W].
  - When Blocks_done==Cfg_inject_blk in PHY_BUSY of the first operation, Complete is withheld.
  - Timeout then pulses for 1 cycle after latched Timeout_reg cycles; the state goes to WAIT_DONE without incrementing Blocks_done.
  - Data_transfer_complete there counts the operation as done.
- **Not defined**: port absent; Timeout tied 0.

Test Plan:
- **Reset**: Reset=0 mid-PHY_BUSY -> all outputs 0 asynchronously, state IDLE; release, Start works normally.
- **Single write**: write, Blocks=2, repeat=1 -> NewData 4 cycles; two FIFO_ok with data A5A50000, A5A50001; two Complete 6 cycles after each Send; DUT completion -> Done=1, Ops_done=1.
- **Multi-op run**: repeat=3, Blocks=1, read -> 3 NewData pulses separated by >=3 idle cycles; Ops_done=3; last data word A5A50002.
- **Zero config**: Cfg_blocks=0 -> Done=1 one cycle after Start; no NewData or FIFO_ok.
- **Watchdog**: DUT never raises Send -> Error=1 after 256 cycles in WAIT_SEND; a new Start clears it.
- **Early completion**: Data_transfer_complete during PHY_BUSY -> Error=1 next cycle. With TIMEOUT_INJ_EN, inject_blk=0 and Timeout_reg=70 -> Timeout pulse 70 cycles after Send, with no Complete.

Source files
------------

// File: rtl/data_seq_gen.sv
// data_seq_gen: run sequencer and PHY emulator for the SD DATA block.
// Macro TIMEOUT_INJ_EN adds Cfg_inject_blk and PHY timeout injection.
module data_seq_gen #(
  parameter int BLK_W = 8,
  parameter int TO_W = 16,
  parameter int DATA_W = 32,
  parameter int REP_W = 4,
  parameter int NEWDATA_CYC = 4,
  parameter int PHY_LAT = 6,
  parameter int GAP_CYC = 3,
  parameter int WDOG_CYC = 256,
  parameter logic [DATA_W-1:0] SEED = DATA_W'(32'hA5A50000)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Cfg_write_read,
  input  logic [BLK_W-1:0]  Cfg_blocks,
  input  logic              Cfg_multiple,
  input  logic              Cfg_timeout_en,
  input  logic [TO_W-1:0]   Cfg_timeout_reg,
  input  logic [REP_W-1:0]  Cfg_repeat,
`ifdef TIMEOUT_INJ_EN
  input  logic [BLK_W-1:0]  Cfg_inject_blk,
`endif
  input  logic              Send,
  input  logic              Idle,
  input  logic              Service,
  input  logic              Data_transfer_complete,
  output logic              WriteRead,
  output logic              MultipleData,
  output logic              Timeout_enable,
  output logic [BLK_W-1:0]  Blocks,
  output logic [TO_W-1:0]   Timeout_reg,
  output logic              NewData,
  output logic              Serial_ready,
  output logic              Complete,
  output logic              FIFO_ok,
  output logic              Timeout,
  output logic [DATA_W-1:0] Data_from_FIFO,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [REP_W-1:0]  Ops_done,
  output logic [BLK_W-1:0]  Blocks_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEWDATA, S_WAIT_SEND, S_PHY_BUSY,
    S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t state, nxt;

  logic [31:0]       tmr;
  logic [REP_W-1:0]  rep;
  logic [DATA_W-1:0] pat;
  logic [BLK_W-1:0]  blk_inc;
  logic [REP_W-1:0]  ops_inc;
  logic              start_ok;
  logic              zero_cfg;
  logic              proto_err;
  logic              inj_hit;
  logic              phy_done;
  logic              to_fire;
  logic              wdog;
  logic              unused_svc;

  assign unused_svc = Service;

  assign blk_inc = Blocks_done + BLK_W'(1);
  assign ops_inc = Ops_done + REP_W'(1);

  assign start_ok = Start &&
    (state inside {S_IDLE, S_DONE, S_ERROR});
  assign zero_cfg = (Cfg_blocks == '0) ||
    (Cfg_repeat == '0);

  assign proto_err =
    (Data_transfer_complete &&
     (state inside {S_NEWDATA, S_WAIT_SEND,
                    S_PHY_BUSY, S_GAP})) ||
    (Idle && state == S_PHY_BUSY);

`ifdef TIMEOUT_INJ_EN
  logic [BLK_W-1:0] inj_blk;
  assign inj_hit = (state == S_PHY_BUSY) &&
    (Ops_done == '0) && (Blocks_done == inj_blk);
`else
  assign inj_hit = 1'b0;
`endif

  assign wdog = (tmr == 32'(WDOG_CYC - 1));

  assign phy_done = (state == S_PHY_BUSY) &&
    !inj_hit && !proto_err &&
    (tmr == 32'(PHY_LAT - 1));

  assign to_fire = inj_hit && !proto_err &&
    ((tmr + 32'd1) >= 32'(Timeout_reg));

  // next-state decode; protocol errors override everything
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start_ok)
          nxt = zero_cfg ? S_DONE : S_NEWDATA;
      S_NEWDATA:
        if (tmr == 32'(NEWDATA_CYC - 1))
          nxt = S_WAIT_SEND;
      S_WAIT_SEND:
        if (Send) nxt = S_PHY_BUSY;
        else if (wdog) nxt = S_ERROR;
      S_PHY_BUSY:
        if (phy_done)
          nxt = (blk_inc == Blocks) ?
            S_WAIT_DONE : S_WAIT_SEND;
        else if (to_fire)
          nxt = S_WAIT_DONE;
      S_WAIT_DONE:
        if (Data_transfer_complete)
          nxt = (ops_inc == rep) ? S_DONE : S_GAP;
        else if (wdog)
          nxt = S_ERROR;
      S_GAP:
        if (tmr == 32'(GAP_CYC - 1))
          nxt = S_NEWDATA;
      default: nxt = S_IDLE;
    endcase
    if (proto_err) nxt = S_ERROR;
  end

  // state, per-state timer, shadow config, counters, pattern
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= S_IDLE;
      tmr            <= '0;
      WriteRead      <= 1'b0;
      MultipleData   <= 1'b0;
      Timeout_enable <= 1'b0;
      Blocks         <= '0;
      Timeout_reg    <= '0;
      rep            <= '0;
`ifdef TIMEOUT_INJ_EN
      inj_blk        <= '0;
`endif
      Ops_done       <= '0;
      Blocks_done    <= '0;
      FIFO_ok        <= 1'b0;
      Data_from_FIFO <= '0;
      pat            <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) tmr <= '0;
      else if (tmr != '1) tmr <= tmr + 32'd1;
      FIFO_ok <= (state == S_WAIT_SEND) &&
                 (nxt == S_PHY_BUSY);
      if (state == S_WAIT_SEND &&
          nxt == S_PHY_BUSY) begin
        Data_from_FIFO <= pat;
        pat            <= pat + DATA_W'(1);
      end
      if (start_ok) begin
        WriteRead      <= Cfg_write_read;
        MultipleData   <= Cfg_multiple;
        Timeout_enable <= Cfg_timeout_en;
        Blocks         <= Cfg_blocks;
        Timeout_reg    <= Cfg_timeout_reg;
        rep            <= Cfg_repeat;
`ifdef TIMEOUT_INJ_EN
        inj_blk        <= Cfg_inject_blk;
`endif
        Ops_done       <= '0;
        Blocks_done    <= '0;
        pat            <= SEED;
      end
      if (phy_done) Blocks_done <= blk_inc;
      if (state == S_WAIT_DONE &&
          Data_transfer_complete) begin
        Ops_done    <= ops_inc;
        Blocks_done <= '0;
      end
    end
  end

  assign NewData      = (state == S_NEWDATA);
  assign Serial_ready = (state == S_WAIT_SEND);
  assign Complete     = phy_done;
  assign Timeout      = to_fire;
  assign Done         = (state == S_DONE);
  assign Error        = (state == S_ERROR);
  assign Busy         = !(state inside
    {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_data_seq_gen.sv
// tb_data_seq_gen: scoreboard bench for data_seq_gen.
// Handshake expectations are queued at stimulus time.
`timescale 1ns/1ps
module tb_data_seq_gen;
  localparam int NDC = 4;
  localparam int LAT = 6;
  localparam int GAP = 3;
  localparam int WDOG = 256;
  localparam logic [31:0] SEED = 32'hA5A50000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Start = 0, Cfg_write_read = 0;
  logic [7:0] Cfg_blocks = 0;
  logic Cfg_multiple = 0, Cfg_timeout_en = 0;
  logic [15:0] Cfg_timeout_reg = 0;
  logic [3:0] Cfg_repeat = 0;
`ifdef TIMEOUT_INJ_EN
  logic [7:0] Cfg_inject_blk = 8'hFF;
`endif
  logic Send = 0, Idle = 0, Service = 0;
  logic Data_transfer_complete = 0;
  logic WriteRead, MultipleData, Timeout_enable;
  logic [7:0] Blocks;
  logic [15:0] Timeout_reg;
  logic NewData, Serial_ready, Complete;
  logic FIFO_ok, Timeout;
  logic [31:0] Data_from_FIFO;
  logic Busy, Done, Error;
  logic [3:0] Ops_done;
  logic [7:0] Blocks_done;

  data_seq_gen dut (
    .Clock(clk), .Reset(rst_n), .Start(Start),
    .Cfg_write_read(Cfg_write_read),
    .Cfg_blocks(Cfg_blocks),
    .Cfg_multiple(Cfg_multiple),
    .Cfg_timeout_en(Cfg_timeout_en),
    .Cfg_timeout_reg(Cfg_timeout_reg),
    .Cfg_repeat(Cfg_repeat),
`ifdef TIMEOUT_INJ_EN
    .Cfg_inject_blk(Cfg_inject_blk),
`endif
    .Send(Send), .Idle(Idle), .Service(Service),
    .Data_transfer_complete(Data_transfer_complete),
    .WriteRead(WriteRead),
    .MultipleData(MultipleData),
    .Timeout_enable(Timeout_enable),
    .Blocks(Blocks), .Timeout_reg(Timeout_reg),
    .NewData(NewData), .Serial_ready(Serial_ready),
    .Complete(Complete), .FIFO_ok(FIFO_ok),
    .Timeout(Timeout),
    .Data_from_FIFO(Data_from_FIFO),
    .Busy(Busy), .Done(Done), .Error(Error),
    .Ops_done(Ops_done), .Blocks_done(Blocks_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int nd_cnt = 0;
  int nd_len = 0;
  bit nd_prev = 0;
  int tgt_blk = 0;

  logic [31:0] q_data[$];
  int q_fok[$];
  int q_cmp[$];
  int q_nd[$];
  int q_to[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: pulse at cycle %0d, required none",
             nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sel(input int w);
    case (w)
      0: return Serial_ready;
      1: return Done;
      2: return Error;
      3: return Blocks_done == 8'(tgt_blk);
      default: return q_to.size() == 0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int w,
                          input int budget, output bit ok);
    int n = 0;
    while (!sel(w) && n < budget) begin
      tick();
      n++;
    end
    ok = sel(w);
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no event in %0d cycles, required event",
               nm, budget);
    end
  endtask

  // scoreboard monitor, samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nd_prev = 0;
        nd_len = 0;
      end else begin
        if (FIFO_ok) begin
          if (q_data.size() == 0 || q_fok.size() == 0)
            unexp("fifo_ok");
          else begin
            chk("fifo_data", Data_from_FIFO, q_data.pop_front());
            chk("fifo_cycle", cyc, q_fok.pop_front());
          end
        end
        if (Complete) begin
          if (q_cmp.size() == 0) unexp("complete");
          else chk("complete_cycle", cyc, q_cmp.pop_front());
        end
        if (Timeout) begin
          if (q_to.size() == 0) unexp("timeout");
          else chk("timeout_cycle", cyc, q_to.pop_front());
        end
        if (NewData && !nd_prev) begin
          if (q_nd.size() == 0) unexp("newdata");
          else chk("newdata_start", cyc, q_nd.pop_front());
        end
        if (NewData) nd_len++;
        else if (nd_prev) begin
          chk("newdata_len", nd_len, NDC);
          nd_cnt++;
          nd_len = 0;
        end
        nd_prev = NewData;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      Service = 1'($urandom);
    end
  end

  task automatic start_run(input int nb, input int nr,
                           input bit wr, input bit ml,
                           input bit te,
                           input logic [15:0] to);
    Cfg_write_read = wr;
    Cfg_blocks = 8'(nb);
    Cfg_repeat = 4'(nr);
    Cfg_multiple = ml;
    Cfg_timeout_en = te;
    Cfg_timeout_reg = to;
    Start = 1;
    if (nb != 0 && nr != 0) q_nd.push_back(cyc + 1);
    tick();
    Start = 0;
    Cfg_write_read = 1'($urandom);
    Cfg_blocks = 8'($urandom);
    Cfg_repeat = 4'($urandom);
    Cfg_multiple = 1'($urandom);
    Cfg_timeout_en = 1'($urandom);
    Cfg_timeout_reg = 16'($urandom);
  endtask

  task automatic send_once();
    Send = 1;
    q_fok.push_back(cyc + 1);
    tick();
    Send = 0;
  endtask

  task automatic do_run(input int nb, input int nr,
                        input bit wr, input int sd_max);
    bit ok;
    bit ml = 1'($urandom);
    bit te = 1'($urandom);
    logic [15:0] to = 16'($urandom);
    int nd0 = nd_cnt;
    for (int k = 0; k < nb * nr; k++)
      q_data.push_back(SEED + 32'(k));
    start_run(nb, nr, wr, ml, te, to);
    chk("busy_after_start", Busy, 1);
    chk("done_cleared", Done, 0);
    chk("error_cleared", Error, 0);
    for (int op = 0; op < nr; op++) begin
      for (int b = 0; b < nb; b++) begin
        wait_for("serial_ready", 0, 200, ok);
        if (!ok) return;
        repeat ($urandom_range(sd_max, 0)) tick();
        q_cmp.push_back(cyc + LAT);
        send_once();
      end
      tgt_blk = nb;
      wait_for("blocks_done", 3, 200, ok);
      if (!ok) return;
      repeat ($urandom_range(5, 0)) tick();
      Data_transfer_complete = 1;
      if (op + 1 < nr) q_nd.push_back(cyc + 1 + GAP);
      tick();
      Data_transfer_complete = 0;
      chk("ops_done", Ops_done, op + 1);
      chk("blocks_done_clr", Blocks_done, 0);
    end
    chk("done_end", Done, 1);
    chk("busy_end", Busy, 0);
    chk("error_end", Error, 0);
    chk("latched_cfg",
        {WriteRead, MultipleData, Timeout_enable,
         Blocks, Timeout_reg},
        {wr, ml, te, 8'(nb), to});
    chk("last_word", Data_from_FIFO,
        SEED + 32'(nb * nr - 1));
    chk("newdata_count", nd_cnt - nd0, nr);
    chk("queues_empty",
        q_data.size() + q_fok.size() +
        q_cmp.size() + q_nd.size(), 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_cfg"},
        {WriteRead, MultipleData, Timeout_enable,
         Blocks, Timeout_reg}, 0);
    chk({nm, "_hs"},
        {NewData, Serial_ready, Complete, FIFO_ok,
         Timeout, Busy, Done, Error,
         Ops_done, Blocks_done}, 0);
    chk({nm, "_data"}, Data_from_FIFO, 0);
  endtask

  initial begin
    bit ok;
    int w;
    #2;
    chk_reset("reset_init");
    tick();
    rst_n = 1;
    tick();

    do_run(2, 1, 1, 3);
    do_run(1, 3, 0, 3);
    for (int i = 0; i < 5; i++)
      do_run($urandom_range(4, 1), $urandom_range(3, 1),
             1'($urandom), 4);

    start_run(1, 1, 1, 0, 0, 16'd0);
    wait_for("wd_serial_ready", 0, 50, ok);
    w = cyc;
    wait_for("wd_error", 2, 400, ok);
    chk("wdog_cycle", cyc, w + WDOG);
    chk("wdog_busy", Busy, 0);
    chk("wdog_sready", Serial_ready, 0);

    start_run(0, 2, 0, 0, 0, 16'd0);
    chk("zero_blk_done", Done, 1);
    chk("zero_blk_err", Error, 0);
    chk("zero_blk_busy", Busy, 0);
    w = nd_cnt;
    start_run(3, 0, 1, 0, 0, 16'd0);
    chk("zero_rep_done", Done, 1);
    repeat (10) tick();
    chk("zero_no_newdata", nd_cnt - w, 0);

    q_data.push_back(SEED);
    start_run(2, 1, 1, 0, 0, 16'd0);
    wait_for("early_sready", 0, 50, ok);
    send_once();
    tick();
    Data_transfer_complete = 1;
    tick();
    Data_transfer_complete = 0;
    chk("early_cmpl_err", Error, 1);
    chk("early_cmpl_busy", Busy, 0);

    q_data.push_back(SEED);
    start_run(2, 1, 0, 0, 0, 16'd0);
    chk("err_cleared_by_start", Error, 0);
    wait_for("idle_sready", 0, 50, ok);
    send_once();
    Idle = 1;
    tick();
    Idle = 0;
    chk("idle_phy_err", Error, 1);

    q_data.push_back(SEED);
    q_data.push_back(SEED + 32'd1);
    start_run(2, 1, 1, 1, 1, 16'h1234);
    wait_for("rst_sready", 0, 50, ok);
    send_once();
    tick();
    #2;
    rst_n = 0;
    #1;
    chk_reset("reset_async");
    q_data.delete();
    q_fok.delete();
    q_cmp.delete();
    q_nd.delete();
    tick();
    tick();
    rst_n = 1;
    tick();
    do_run(2, 2, 1, 3);

`ifdef TIMEOUT_INJ_EN
    Cfg_inject_blk = 8'd0;
    q_data.push_back(SEED);
    start_run(2, 1, 1, 0, 1, 16'd70);
    Cfg_inject_blk = 8'hFF;
    wait_for("inj_sready", 0, 50, ok);
    q_to.push_back(cyc + 70);
    send_once();
    wait_for("inj_timeout", 4, 120, ok);
    tick();
    chk("inj_blocks_done", Blocks_done, 0);
    Data_transfer_complete = 1;
    tick();
    Data_transfer_complete = 0;
    chk("inj_ops_done", Ops_done, 1);
    chk("inj_done", Done, 1);
    chk("inj_error", Error, 0);
`endif

    do_run(3, 2, 0, 2);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: time %0t, required finish",
             $time);
    $fatal(1, "global timeout");
  end

endmodule
